// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and decode helpers for muldiv_unit
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (mode 0) or restoring trial-subtract (mode 1) iteration
// The divide path exists only when RV_MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
`ifdef RV_MULDIV_DIV_EN
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    // Multiply: conditionally add into the upper half, keep the carry, shift right.
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    acc_next = {sum, acc[XLEN-1:1]};
`ifdef RV_MULDIV_DIV_EN
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = shifted - {1'b0, operand};
    if (mode) begin
      if (!diff[XLEN])
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with request/response handshakes
// Define RV_MULDIV_DIV_EN to build the divider; otherwise divide ops complete with resp_err.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [2*XLEN-1:0]   acc, acc_next, prod;
  logic [XLEN-1:0]     operand, mag_a, mag_b, result, spec_data;
  logic                sign_a, sign_b, neg_lo, special, last_step;

  assign sign_a    = is_signed_a(req_op) && req_a[XLEN-1];
  assign sign_b    = is_signed_b(req_op) && req_b[XLEN-1];
  assign mag_a     = sign_a ? -req_a : req_a;
  assign mag_b     = sign_b ? -req_b : req_b;
  assign last_step = (cnt == CNT_W'(1));
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);

`ifdef RV_MULDIV_DIV_EN
  logic neg_rem, div_zero, div_ovf;
  assign div_zero  = (req_b == '0);
  assign div_ovf   = is_signed_b(req_op) && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b);
  assign special   = is_div(req_op) && (div_zero || div_ovf);
  // op bit 1 distinguishes REM/REMU from DIV/DIVU
  assign spec_data = req_op[1] ? (div_zero ? req_a : '0) : (div_zero ? '1 : req_a);
  assign resp_err  = 1'b0;
`else
  logic err_q;
  assign special   = is_div(req_op);
  assign spec_data = '0;
  assign resp_err  = err_q;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (is_div(op_q)),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_comb begin
    prod   = neg_lo ? -acc_next : acc_next;
    result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef RV_MULDIV_DIV_EN
    if (is_div(op_q)) begin
      if (op_q[1])
        result = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
      else
        result = neg_lo ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = special ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= OP_MUL;
      acc       <= '0;
      operand   <= '0;
      neg_lo    <= 1'b0;
      resp_data <= '0;
`ifdef RV_MULDIV_DIV_EN
      neg_rem   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q <= req_op;
          cnt  <= CNT_W'(XLEN);
          if (special) begin
            resp_data <= spec_data;
          end else begin
            acc     <= {{XLEN{1'b0}}, mag_a};
            operand <= mag_b;
            neg_lo  <= sign_a ^ sign_b;
`ifdef RV_MULDIV_DIV_EN
            neg_rem <= sign_a;
`endif
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (last_step) resp_data <= result;
        end
        default: ;
      endcase
    end
  end

`ifndef RV_MULDIV_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_q <= 1'b0;
    else if (state == IDLE && req_valid)    err_q <= special;
  end
`endif

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit executing the RV32M operation set on a parametrised operand width, attached beside the integer ALU in the execute stage. Accepts one operation through a valid/ready request handshake and computes it over XLEN cycles with a shift-add multiplier and restoring divider. Returns a registered result through a valid/ready response handshake. It supersedes fixed single-cycle arithmetic for the M extension without lengthening the ALU critical path.

## Interface
- XLEN, 32: operand and result width; must be even and at least 8.
- CNT_W, $clog2(XLEN)+1: step counter width; derived, not overridden.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  in  XLEN  rs1 operand
- req_b  in  XLEN  rs2 operand
- resp_valid  out  1  result valid; high only in DONE
- resp_ready  in  1  consumer takes result
- resp_data  out  XLEN  result
- resp_err  out  1  operation unsupported in this build

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on req_valid && req_ready.
  - Latch the op.
  - Latch operand magnitudes and result-sign flags.
  - Load the counter with XLEN.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Special cases go IDLE -> DONE directly, with no CALC:
  - Divide by zero: quotient all-ones; remainder = req_a.
  - Signed overflow (a = most-negative, b = -1): quotient = req_a; remainder 0.
- Multiply step, one per CALC cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of a 2*XLEN accumulator.
  - Shift the accumulator right by 1.
- Divide step, one per CALC cycle:
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor from the remainder; if the result is non-negative, keep it and set quotient LSB.
- Counter decrements each CALC cycle. At the step where it reaches 0:
  - Apply sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the result: MUL takes the low XLEN bits, MULH* the high XLEN bits.
  - Write resp_data and go to DONE.
- DONE -> IDLE on resp_ready. resp_data holds until the next result is written.
- No request is accepted in the cycle the response retires. There is no bypass.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - req_ready 1, resp_valid 0, resp_data 0, resp_err 0.
  - Internal accumulators 0.
- Normal latency: resp_valid rises XLEN+1 clock edges after the accepting edge (33 for XLEN=32).
- Special-case latency: resp_valid rises 1 edge after acceptance.
- Throughput: at most one operation per XLEN+2 cycles.
- req_* inputs are sampled only on the accepting edge; later changes are ignored.
- While resp_valid=1 && resp_ready=0, resp_data and resp_err are stable and req_ready=0.
- Reset asserted in any state returns to IDLE immediately. The in-flight operation is discarded and no response is produced.

## Configuration
- RV_MULDIV_DIV_EN defined:
  - Divider and special-case logic are present.
  - resp_err is constant 0.
- RV_MULDIV_DIV_EN undefined:
  - Divider logic is removed.
  - Ops 100–111 are accepted and go IDLE -> DONE in 1 edge, with resp_data 0 and resp_err 1.
  - Multiply behaviour is unchanged.

## Structure
- Package muldiv_pkg holds:
  - Op encoding constants (OP_MUL … OP_REMU).
  - State enum (IDLE, CALC, DONE).
  - is_div/is_signed_a/is_signed_b helper functions.
- Sub-module muldiv_step, combinational: one shift-add or trial-subtract iteration, selected by mode. It is instantiated once in muldiv_unit.

## Test plan
XLEN=32 unless stated.
- MUL 7 × 0xFFFFFFFD (-3) -> resp_data 0xFFFFFFEB, resp_valid 33 edges after accept, resp_err 0.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each valid after 1 edge. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles -> resp_data stable, req_ready 0; retires on the first resp_ready=1 edge.
  - Assert rst mid-CALC -> IDLE, req_ready 1, no resp_valid.
- Build without RV_MULDIV_DIV_EN -> DIV 10/2 returns 0 with resp_err 1 after 1 edge. MUL 6 × 7 still returns 42.
